// File: rtl/accel_pkg.sv
// Shared register map, CSR bit positions and sequencer states for the accelerator CSR/FIFO stage.
package accel_pkg;

  localparam logic [7:0] ADR_CTRL   = 8'h00;
  localparam logic [7:0] ADR_STATUS = 8'h04;
  localparam logic [7:0] ADR_DIN    = 8'h08;
  localparam logic [7:0] ADR_DOUT   = 8'h0C;
  localparam logic [7:0] ADR_KEY0   = 8'h10;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_CLR    = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_IN_FULL   = 2;
  localparam int unsigned ST_IN_EMPTY  = 3;
  localparam int unsigned ST_OUT_FULL  = 4;
  localparam int unsigned ST_OUT_EMPTY = 5;
  localparam int unsigned ST_IN_OVF    = 6;
  localparam int unsigned ST_OUT_UDF   = 7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/accel_sync_fifo.sv
// Single-clock FIFO with flush; a push is refused when full and a pop when empty, judged at cycle start.
module accel_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is forced to zero when empty so the stage drives clean outputs out of reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accel_csr_fifo.sv
// CSR decode, data FIFOs and start/busy/done sequencer for the crypto core.
// Define ACCEL_IRQ_EN to add the CTRL IRQ_EN bit and the registered irq_o output.
module accel_csr_fifo
  import accel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned KEY_WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    wb_rst_i,
  input  logic [7:0]              reg_adr_i,
  input  logic [31:0]             reg_wdata_i,
  input  logic                    reg_we_i,
  input  logic                    reg_re_i,
  output logic [31:0]             reg_rdata_o,
  output logic                    core_start_o,
  input  logic                    core_done_i,
  output logic                    core_busy_o,
  output logic [32*KEY_WORDS-1:0] key_o,
  output logic [31:0]             in_tdata_o,
  output logic                    in_tvalid_o,
  input  logic                    in_tready_i,
  input  logic [31:0]             out_tdata_i,
  input  logic                    out_tvalid_i,
  output logic                    out_tready_o
`ifdef ACCEL_IRQ_EN
  ,
  output logic                    irq_o
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  state_t        state_nxt;
  logic          start_q;
  logic [5:0]    idx;
  logic          ctrl_wr, status_wr, din_wr, dout_rd;
  logic          start_wr, clr;
  logic          done_f, in_ovf, out_udf;
  logic          in_full, in_empty, out_full, out_empty;
  logic [CW-1:0] in_count, out_count;
  logic [31:0]   out_head;
  logic [31:0]   ctrl_rd, status_rd;
  logic [31:0]   key [KEY_WORDS];
  logic          adr_unused;

  assign idx        = reg_adr_i[7:2];
  assign adr_unused = ^reg_adr_i[1:0];
  assign ctrl_wr    = reg_we_i && (idx == ADR_CTRL[7:2]);
  assign status_wr  = reg_we_i && (idx == ADR_STATUS[7:2]);
  assign din_wr     = reg_we_i && (idx == ADR_DIN[7:2]);
  assign dout_rd    = reg_re_i && (idx == ADR_DOUT[7:2]);
  assign start_wr   = ctrl_wr && reg_wdata_i[CTRL_START];
  assign clr        = ctrl_wr && reg_wdata_i[CTRL_CLR];

  accel_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_in_fifo (
    .clk(clk), .rst(wb_rst_i), .flush(clr), .push(din_wr), .pop(in_tready_i),
    .din(reg_wdata_i), .dout(in_tdata_o), .full(in_full), .empty(in_empty), .count(in_count)
  );

  accel_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_out_fifo (
    .clk(clk), .rst(wb_rst_i), .flush(clr), .push(out_tvalid_i), .pop(dout_rd),
    .din(out_tdata_i), .dout(out_head), .full(out_full), .empty(out_empty), .count(out_count)
  );

  assign in_tvalid_o  = ~in_empty;
  assign out_tready_o = ~out_full;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= (state == IDLE) && start_wr;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_wr) state_nxt = RUN;
      RUN:     if (core_done_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    core_busy_o  = (state == RUN);
    core_start_o = start_q;
  end

  // A DONE set event outranks a same-cycle write-1-clear.
  always_ff @(posedge clk) begin
    if (wb_rst_i || clr) begin
      done_f  <= 1'b0;
      in_ovf  <= 1'b0;
      out_udf <= 1'b0;
    end else begin
      done_f  <= (state == DONE) | (done_f & ~(status_wr & reg_wdata_i[ST_DONE]));
      in_ovf  <= in_ovf | (din_wr & in_full);
      out_udf <= out_udf | (dout_rd & out_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      for (int unsigned k = 0; k < KEY_WORDS; k++) key[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < KEY_WORDS; k++)
        if (reg_we_i && (idx == ADR_KEY0[7:2] + 6'(k))) key[k] <= reg_wdata_i;
    end
  end

  always_comb begin
    key_o = '0;
    for (int unsigned k = 0; k < KEY_WORDS; k++) key_o[32*k +: 32] = key[k];
  end

`ifdef ACCEL_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= reg_wdata_i[CTRL_IRQ_EN];
      irq_o <= irq_en & (done_f | in_ovf | out_udf);
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_IRQ_EN] = irq_en;
  end
`else
  assign ctrl_rd = '0;
`endif

  always_comb begin
    status_rd               = '0;
    status_rd[ST_BUSY]      = (state == RUN);
    status_rd[ST_DONE]      = done_f;
    status_rd[ST_IN_FULL]   = in_full;
    status_rd[ST_IN_EMPTY]  = in_empty;
    status_rd[ST_OUT_FULL]  = out_full;
    status_rd[ST_OUT_EMPTY] = out_empty;
    status_rd[ST_IN_OVF]    = in_ovf;
    status_rd[ST_OUT_UDF]   = out_udf;
    status_rd[15:8]         = 8'(in_count);
    status_rd[23:16]        = 8'(out_count);
  end

  always_comb begin
    reg_rdata_o = '0;
    if (idx == ADR_CTRL[7:2])        reg_rdata_o = ctrl_rd;
    else if (idx == ADR_STATUS[7:2]) reg_rdata_o = status_rd;
    else if (idx == ADR_DOUT[7:2])   reg_rdata_o = out_head;
    else begin
      for (int unsigned k = 0; k < KEY_WORDS; k++)
        if (idx == ADR_KEY0[7:2] + 6'(k)) reg_rdata_o = key[k];
    end
  end

endmodule
